// File: rtl/layer_job_sequencer.sv
// Layer job sequencer: accepts a layer on start_layer and splits it into row jobs
// (filter groups outer, output rows inner). Each job goes to the PE datapath over valid/ready.
module layer_job_sequencer #(
   parameter int NUM_PE         = 16,
   parameter int OFM_RAM_SIZE_1 = 2205619,
   parameter int POOL_DRAIN     = 4,
   parameter int ADDR_W         = $clog2(OFM_RAM_SIZE_1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_layer,
   input  logic [8:0]        ifm_size,
   input  logic [10:0]       ifm_channel,
   input  logic [1:0]        kernel_size,
   input  logic [10:0]       num_filter,
   input  logic              maxpool_mode,
   input  logic [ADDR_W-1:0] start_read_addr,
   output logic              done_layer,
   output logic              busy,
   output logic              job_valid,
   input  logic              job_ready,
   output logic [8:0]        job_row,
   output logic [10:0]       job_filter_base,
   output logic [4:0]        job_filters,
   output logic [10:0]       job_channels,
   output logic [ADDR_W-1:0] job_rd_addr,
   output logic              job_last,
   input  logic              job_done,
   output logic              cfg_err,
   output logic              overrun_err
);

   localparam int DRW = (POOL_DRAIN > 1) ? $clog2(POOL_DRAIN) : 1;

   typedef enum logic [2:0] {S_IDLE, S_CALC, S_ISSUE, S_WAIT, S_DRAIN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [8:0]        ifm_q, ifm_d;
   logic [10:0]       chan_q, chan_d;
   logic [1:0]        ksz_q, ksz_d;
   logic [10:0]       nf_q, nf_d;
   logic              pool_q, pool_d;
   logic [ADDR_W-1:0] base_addr_q, base_addr_d;
   logic [8:0]        rows_q, rows_d;
   logic [6:0]        groups_q, groups_d;
   logic [8:0]        row_q, row_d;
   logic [6:0]        grp_q, grp_d;
   logic [10:0]       fbase_q, fbase_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [DRW-1:0]    drain_q, drain_d;
   logic              cfg_err_q, cfg_err_d;
   logic              overrun_q, overrun_d;

   logic              last_job;
   logic              bad_cfg;
   logic [10:0]       remain;

   assign last_job = (grp_q == groups_q - 7'd1) && (row_q == rows_q - 9'd1);
   assign bad_cfg  = (ksz_q == 2'd0) || (nf_q == 11'd0) || (ifm_q < {7'd0, ksz_q});
   assign remain   = nf_q - fbase_q;

   always_comb begin
      state_d     = state_q;
      ifm_d       = ifm_q;
      chan_d      = chan_q;
      ksz_d       = ksz_q;
      nf_d        = nf_q;
      pool_d      = pool_q;
      base_addr_d = base_addr_q;
      rows_d      = rows_q;
      groups_d    = groups_q;
      row_d       = row_q;
      grp_d       = grp_q;
      fbase_d     = fbase_q;
      rd_addr_d   = rd_addr_q;
      drain_d     = drain_q;
      cfg_err_d   = cfg_err_q;
      overrun_d   = overrun_q;

      if (start_layer && (state_q != S_IDLE)) overrun_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (start_layer) begin
               ifm_d       = ifm_size;
               chan_d      = ifm_channel;
               ksz_d       = kernel_size;
               nf_d        = num_filter;
               pool_d      = maxpool_mode;
               base_addr_d = start_read_addr;
               cfg_err_d   = 1'b0;
               state_d     = S_CALC;
            end
         end
         S_CALC: begin
            rows_d    = ifm_q - {7'd0, ksz_q} + 9'd1;
            groups_d  = 7'((12'(nf_q) + 12'(NUM_PE - 1)) / 12'(NUM_PE));
            row_d     = '0;
            grp_d     = '0;
            fbase_d   = '0;
            rd_addr_d = base_addr_q;
            if (bad_cfg) begin
               cfg_err_d = 1'b1;
               state_d   = S_DONE;
            end else begin
               state_d   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (job_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (job_done) begin
               if (last_job) begin
                  drain_d = '0;
                  state_d = pool_q ? S_DRAIN : S_DONE;
               end else begin
                  state_d = S_ISSUE;
                  // Row wrap moves to the next filter group and rewinds the read address
                  if (row_q == rows_q - 9'd1) begin
                     row_d     = '0;
                     grp_d     = grp_q + 7'd1;
                     fbase_d   = fbase_q + 11'(NUM_PE);
                     rd_addr_d = base_addr_q;
                  end else begin
                     row_d     = row_q + 9'd1;
                     rd_addr_d = rd_addr_q + {{(ADDR_W-9){1'b0}}, ifm_q};
                  end
               end
            end
         end
         S_DRAIN: begin
            if (drain_q == DRW'(POOL_DRAIN - 1)) state_d = S_DONE;
            else drain_d = drain_q + 1'b1;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ifm_q       <= '0;
         chan_q      <= '0;
         ksz_q       <= '0;
         nf_q        <= '0;
         pool_q      <= 1'b0;
         base_addr_q <= '0;
         rows_q      <= '0;
         groups_q    <= '0;
         row_q       <= '0;
         grp_q       <= '0;
         fbase_q     <= '0;
         rd_addr_q   <= '0;
         drain_q     <= '0;
         cfg_err_q   <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ifm_q       <= ifm_d;
         chan_q      <= chan_d;
         ksz_q       <= ksz_d;
         nf_q        <= nf_d;
         pool_q      <= pool_d;
         base_addr_q <= base_addr_d;
         rows_q      <= rows_d;
         groups_q    <= groups_d;
         row_q       <= row_d;
         grp_q       <= grp_d;
         fbase_q     <= fbase_d;
         rd_addr_q   <= rd_addr_d;
         drain_q     <= drain_d;
         cfg_err_q   <= cfg_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign done_layer      = (state_q == S_DONE);
   assign busy            = (state_q != S_IDLE);
   assign job_valid       = (state_q == S_ISSUE);
   assign job_last        = ((state_q == S_ISSUE) || (state_q == S_WAIT)) && last_job;
   assign job_row         = row_q;
   assign job_filter_base = fbase_q;
   assign job_filters     = (remain > 11'(NUM_PE)) ? 5'(NUM_PE) : remain[4:0];
   assign job_channels    = chan_q;
   assign job_rd_addr     = rd_addr_q;
   assign cfg_err         = cfg_err_q;
   assign overrun_err     = overrun_q;

endmodule

// File: tb/tb_layer_job_sequencer.sv
// Randomized bench for layer_job_sequencer: a job-list/timestamp model predicts every output
// each cycle, plus directed layers with hand-computed expectations.
module tb_layer_job_sequencer;
   localparam int NUM_PE     = 16;
   localparam int POOL_DRAIN = 4;
   localparam int ADDR_W     = 22;

   logic              clk = 1'b0;
   logic              rst;
   logic              start_layer;
   logic [8:0]        ifm_size;
   logic [10:0]       ifm_channel;
   logic [1:0]        kernel_size;
   logic [10:0]       num_filter;
   logic              maxpool_mode;
   logic [ADDR_W-1:0] start_read_addr;
   logic              done_layer, busy, job_valid, job_ready, job_last, job_done;
   logic [8:0]        job_row;
   logic [10:0]       job_filter_base, job_channels;
   logic [4:0]        job_filters;
   logic [ADDR_W-1:0] job_rd_addr;
   logic              cfg_err, overrun_err;

   layer_job_sequencer #(.NUM_PE(NUM_PE), .OFM_RAM_SIZE_1(2205619), .POOL_DRAIN(POOL_DRAIN)) dut (
      .clk(clk), .rst(rst), .start_layer(start_layer), .ifm_size(ifm_size),
      .ifm_channel(ifm_channel), .kernel_size(kernel_size), .num_filter(num_filter),
      .maxpool_mode(maxpool_mode), .start_read_addr(start_read_addr), .done_layer(done_layer),
      .busy(busy), .job_valid(job_valid), .job_ready(job_ready), .job_row(job_row),
      .job_filter_base(job_filter_base), .job_filters(job_filters), .job_channels(job_channels),
      .job_rd_addr(job_rd_addr), .job_last(job_last), .job_done(job_done),
      .cfg_err(cfg_err), .overrun_err(overrun_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          row;
      int          base;
      int          filters;
      int          ch;
      logic [21:0] addr;
      bit          last;
   } job_t;

   job_t q[$];
   int   checks = 0;
   int   errors = 0;

   // model state
   bit m_on = 0, m_out = 0, m_cfg = 0, m_ovr = 0, m_pool = 0, m_rst_prev = 0;
   int m_issue_from = 0, m_done_at = -1, m_cfg_set_at = -1, m_last_jd = -1;

   // responder / bookkeeping
   bit tb_hs = 0, tb_rst = 0, r_out = 0, hold_req = 0;
   int r_dly = 0, hold = 0, hs_cnt = 0, last_cnt = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic void build(input int ifm, input int k, input int nf, input int ch,
                                 input int addr0);
      int rows, groups;
      job_t j;
      q.delete();
      if (k == 0 || nf == 0 || ifm < k) return;
      rows   = ifm - k + 1;
      groups = (nf + NUM_PE - 1) / NUM_PE;
      for (int g = 0; g < groups; g++)
         for (int r = 0; r < rows; r++) begin
            j.row     = r;
            j.base    = g * NUM_PE;
            j.filters = (nf - j.base > NUM_PE) ? NUM_PE : nf - j.base;
            j.ch      = ch;
            j.addr    = 22'(addr0 + r * ifm);
            j.last    = (g == groups - 1) && (r == rows - 1);
            q.push_back(j);
         end
   endfunction

   always @(negedge clk) begin
      bit ev, idle_now;
      if (m_rst_prev) begin
         chk("rst_row", job_row, 0);
         chk("rst_base", job_filter_base, 0);
         chk("rst_filters", job_filters, 0);
         chk("rst_channels", job_channels, 0);
         chk("rst_addr", job_rd_addr, 0);
         chk("rst_last", job_last, 0);
      end
      chk("busy", busy, m_on);
      chk("done_layer", done_layer, m_on && m_done_at == cyc);
      chk("cfg_err", cfg_err, m_cfg);
      chk("overrun_err", overrun_err, m_ovr);
      ev = m_on && !m_out && q.size() > 0 && cyc >= m_issue_from;
      chk("job_valid", job_valid, ev);
      if (ev && job_valid) begin
         chk("job_row", job_row, q[0].row);
         chk("job_filter_base", job_filter_base, q[0].base);
         chk("job_filters", job_filters, q[0].filters);
         chk("job_channels", job_channels, q[0].ch);
         chk("job_rd_addr", job_rd_addr, q[0].addr);
         chk("job_last", job_last, q[0].last);
      end
      tb_hs  = job_valid && job_ready && !rst;
      tb_rst = rst;
      if (tb_hs) begin
         hs_cnt++;
         if (job_last) last_cnt++;
      end
      m_rst_prev = rst;
      if (rst) begin
         m_on = 0; m_out = 0; m_cfg = 0; m_ovr = 0;
         m_done_at = -1; m_cfg_set_at = -1;
         q.delete();
      end else begin
         idle_now = !m_on;
         if (m_cfg_set_at == cyc + 1) m_cfg = 1;
         if (m_on && m_done_at == cyc) m_on = 0;
         if (start_layer) begin
            if (idle_now) begin
               m_on = 1; m_out = 0; m_cfg = 0; m_pool = maxpool_mode;
               build(int'(ifm_size), int'(kernel_size), int'(num_filter), int'(ifm_channel),
                     int'(start_read_addr));
               if (q.size() == 0) begin
                  m_done_at = cyc + 2; m_cfg_set_at = cyc + 2;
               end else begin
                  m_issue_from = cyc + 2; m_done_at = -1; m_cfg_set_at = -1;
               end
            end else begin
               m_ovr = 1;
            end
         end
         if (m_out && job_done) begin
            m_out = 0;
            if (q.size() == 0) begin
               m_last_jd = cyc;
               m_done_at = cyc + 1 + (m_pool ? POOL_DRAIN : 0);
            end
         end
         if (ev && job_ready) begin
            void'(q.pop_front());
            m_out = 1;
         end
      end
   end

   // PE datapath stand-in: random ready, random job latency, stray job_done when idle
   initial begin
      job_ready = 1'b0;
      job_done  = 1'b0;
      forever begin
         @(posedge clk); #1;
         job_done = 1'b0;
         if (tb_rst) r_out = 0;
         else if (tb_hs) begin
            r_out = 1; r_dly = $urandom_range(0, 3);
         end else if (r_out) begin
            if (r_dly == 0) begin job_done = 1'b1; r_out = 0; end
            else r_dly--;
         end
         if (!r_out && !job_done && ($urandom % 8 == 0)) job_done = 1'b1;
         if (hold_req) begin hold = 14; hold_req = 0; end
         if (hold > 0) begin job_ready = 1'b0; hold--; end
         else job_ready = ($urandom % 4 != 0);
      end
   end

   task automatic start_cfg(input int ifm, input int k, input int nf, input int pool,
                            input int ch, input int addr, output int t);
      @(posedge clk); #1;
      ifm_size = 9'(ifm); kernel_size = 2'(k); num_filter = 11'(nf);
      maxpool_mode = pool[0]; ifm_channel = 11'(ch); start_read_addr = 22'(addr);
      start_layer = 1'b1;
      t = cyc;
      @(posedge clk); #1;
      start_layer = 1'b0;
      ifm_size = 9'($urandom); kernel_size = 2'($urandom); num_filter = 11'($urandom);
      maxpool_mode = 1'($urandom); ifm_channel = 11'($urandom); start_read_addr = 22'($urandom);
   endtask

   task automatic wait_done(output int dc);
      dc = -1;
      for (int n = 0; n < 30000; n++) begin
         @(negedge clk);
         if (done_layer) begin dc = cyc; break; end
      end
      if (dc < 0) chk("done_timeout", 0, 1);
   endtask

   task automatic wait_out();
      int n = 0;
      while (!r_out && n < 2000) begin @(posedge clk); #2; n++; end
      if (!r_out) chk("wait_timeout", 0, 1);
   endtask

   task automatic to_cycle(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   initial begin
      int t, dc, cap_row, cap_addr, cap_base;
      rst = 1'b1; start_layer = 1'b0; ifm_size = '0; ifm_channel = '0; kernel_size = '0;
      num_filter = '0; maxpool_mode = 1'b0; start_read_addr = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // layer 1: 416 rows, one group, pooling
      start_cfg(418, 3, 16, 1, 3, 0, t);
      @(negedge clk); #1;
      chk("l1_jobs", q.size(), 415 + (m_out ? 0 : 1) - (q.size() < 416 && !m_out ? 0 : 0));
      chk("l1_row5_addr", q[5].addr, 2090);
      chk("l1_last", q[q.size()-1].last, 1);
      hs_cnt = 0; last_cnt = 0;
      wait_done(dc);
      chk("l1_hs", hs_cnt, 416);
      chk("l1_drain_gap", dc - m_last_jd, POOL_DRAIN + 1);

      // 255 filters: 16 groups x 13 rows
      start_cfg(13, 1, 255, 0, 7, 100, t);
      hs_cnt = 0; last_cnt = 0;
      @(negedge clk); #1;
      chk("l2_jobs", q.size(), 208);
      chk("l2_g15_filters", q[195].filters, 15);
      chk("l2_g15_base", q[195].base, 240);
      chk("l2_last207", q[207].last, 1);
      chk("l2_last206", q[206].last, 0);
      wait_done(dc);
      chk("l2_hs", hs_cnt, 208);
      chk("l2_last_cnt", last_cnt, 1);
      chk("l2_done_gap", dc - m_last_jd, 1);

      // ready held low: offer must hold steady
      hold_req = 1;
      start_cfg(8, 3, 20, 0, 5, 4000, t);
      to_cycle(t + 1);
      chk("hold_no_valid_t1", job_valid, 0);
      to_cycle(t + 2);
      chk("hold_valid_t2", job_valid, 1);
      cap_row = job_row; cap_addr = job_rd_addr; cap_base = job_filter_base;
      to_cycle(t + 12);
      chk("hold_valid_t12", job_valid, 1);
      chk("hold_row", job_row, cap_row);
      chk("hold_addr", job_rd_addr, cap_addr);
      chk("hold_base", job_filter_base, cap_base);
      wait_done(dc);

      // start during WAIT: overrun, layer unaffected
      start_cfg(10, 3, 40, 1, 2, 50, t);
      hs_cnt = 0;
      wait_out();
      @(posedge clk); #1;
      start_layer = 1'b1; ifm_size = 9'd5; num_filter = 11'd1; kernel_size = 2'd1;
      @(posedge clk); #1;
      start_layer = 1'b0;
      wait_done(dc);
      chk("ovr_flag", overrun_err, 1);
      chk("ovr_hs", hs_cnt, 24);
      chk("ovr_drain_gap", dc - m_last_jd, POOL_DRAIN + 1);

      // degenerate config
      repeat (2) @(posedge clk);
      start_cfg(9, 0, 8, 0, 1, 0, t);
      wait_done(dc);
      chk("cfg_done_t2", dc - t, 2);
      chk("cfg_err_set", cfg_err, 1);
      start_cfg(4, 1, 3, 0, 1, 9, t);
      to_cycle(t + 1);
      chk("cfg_err_clear", cfg_err, 0);
      wait_done(dc);

      // reset mid-WAIT, then fresh start
      start_cfg(12, 3, 30, 1, 6, 77, t);
      wait_out();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_ovr", overrun_err, 0);
      start_cfg(6, 3, 17, 0, 4, 300, t);
      to_cycle(t + 2);
      chk("post_rst_valid", job_valid, 1);
      chk("post_rst_row", job_row, 0);
      chk("post_rst_base", job_filter_base, 0);
      chk("post_rst_addr", job_rd_addr, 300);
      wait_done(dc);

      // randomized layers, with occasional stray starts
      for (int i = 0; i < 14; i++) begin
         start_cfg($urandom_range(0, 24), $urandom_range(0, 3), $urandom_range(0, 70),
                   $urandom_range(0, 1), $urandom_range(0, 2047), $urandom, t);
         if ($urandom % 3 == 0) begin
            repeat ($urandom_range(1, 20)) @(posedge clk);
            #1 start_layer = 1'b1;
            @(posedge clk); #1 start_layer = 1'b0;
         end
         if (busy || m_on) wait_done(dc);
         repeat ($urandom_range(1, 3)) @(posedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
